// File: rtl/sr_latch_driver.sv
// Command-side driver for a gated SR latch: accepts set/reset commands, emits an
// enable-gated S or R pulse, then confirms the level from Q/Q_n feedback.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  input  logic err_clr,
  input  logic q_fb,
  input  logic q_n_fb,
  output logic latch_S,
  output logic latch_R,
  output logic latch_en,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CONFIRM, ST_ERROR} state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_target, w_target_nxt;
  logic             w_done_nxt;
  logic             w_accept, w_cmd_noop, w_fb_match;
  logic             r_cmd_ready, r_busy, r_done, r_err;
  logic             r_latch_s, r_latch_r, r_latch_en;

  assign w_accept   = cmd_valid && r_cmd_ready;
  // Invalid feedback (q_fb == q_n_fb) can never satisfy either comparison.
  assign w_cmd_noop = (q_fb == cmd_set) && (q_n_fb == !cmd_set);
  assign w_fb_match = (q_fb == r_target) && (q_n_fb == !r_target);
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_target_nxt = cmd_set;
          if (w_cmd_noop) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_DRIVE: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = ST_CONFIRM;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_CONFIRM: begin
        if (w_fb_match) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TIMEOUT_LIM) begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (err_clr) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the first drive cycle
  // directly follows the accept edge and S/R can never glitch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_latch_en  <= 1'b0;
      r_latch_s   <= 1'b0;
      r_latch_r   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= w_done_nxt;
      r_err       <= (w_state_nxt == ST_ERROR);
      r_latch_en  <= (w_state_nxt == ST_DRIVE);
      r_latch_s   <= (w_state_nxt == ST_DRIVE) && w_target_nxt;
      r_latch_r   <= (w_state_nxt == ST_DRIVE) && !w_target_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_target <= w_target_nxt;
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign latch_en  = r_latch_en;
  assign latch_S   = r_latch_s;
  assign latch_R   = r_latch_r;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: stimulus predicts each command's outcome
// from timing rules; a monitor checks drive pulses, busy/ready and done/err.
module tb_sr_latch_driver;

  localparam int PW = 2;
  localparam int TO = 8;

  logic clk, rst, cmd_valid, cmd_set, cmd_ready, err_clr, q_fb, q_n_fb;
  logic latch_S, latch_R, latch_en, busy, done, err;

  sr_latch_driver #(.PULSE_W(PW), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .err_clr(err_clr), .q_fb(q_fb), .q_n_fb(q_n_fb),
    .latch_S(latch_S), .latch_R(latch_R), .latch_en(latch_en),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int a;
    bit tgt;
    bit noop;
    bit is_err;
    int o;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp_v);
  endtask

  // Outcome model: mode 0 = feedback already matches (no-op), 1 = opposite level,
  // 2 = invalid. c = cycle (relative to accept) where feedback becomes the target, <=0 never.
  function automatic exp_t predict(input int a, input bit tgt, input int mode, input int c);
    exp_t e;
    int first_cf, last_cf, m;
    e.a = a; e.tgt = tgt; e.noop = (mode == 0);
    first_cf = PW + 1;
    last_cf  = PW + TO;
    if (mode == 0) begin
      e.is_err = 0; e.o = a + 1;
    end else begin
      m = (c > first_cf) ? c : first_cf;
      if (c > 0 && m <= last_cf) begin
        e.is_err = 0; e.o = a + m + 1;
      end else begin
        e.is_err = 1; e.o = a + last_cf + 1;
      end
    end
    return e;
  endfunction

  task automatic run_txn(input bit tgt, input int mode, input int c, input int hold);
    exp_t e;
    int   w, a, hd;
    bit   iv;
    @(negedge clk);
    case (mode)
      0: begin q_fb = tgt;  q_n_fb = !tgt; end
      1: begin q_fb = !tgt; q_n_fb = tgt;  end
      default: begin iv = 1'($urandom_range(0, 1)); q_fb = iv; q_n_fb = iv; end
    endcase
    cmd_set   = tgt;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_chk++;
      $display("FAIL accept_wait: cmd_ready=0 want 1 after %0d cycles", w);
      cmd_valid = 1'b0;
      return;
    end
    a = cyc;
    e = predict(a, tgt, mode, c);
    sb.push_back(e);
    hd = (mode == 0) ? 0 : hold;
    while (cyc < e.o) begin
      @(negedge clk);
      if (cyc - a > hd) cmd_valid = 1'b0;
      err_clr = (cyc < e.o) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode != 0 && c > 0 && cyc == a + c) begin q_fb = tgt; q_n_fb = !tgt; end
    end
    err_clr = 1'b0;
    if (e.is_err) begin
      cmd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk("err_held", err, 1);
        chk("err_blocks_ready", cmd_ready, 0);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      err_clr   = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr_err", err, 0);
      chk("err_clr_ready", cmd_ready, 1);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t h;
    bit   prev_err, err_mode, err_rise, e_drv, e_busy, have;
    prev_err = 0; err_mode = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        err_rise = err && !prev_err;
        if (done || err_rise) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_outcome at cycle %0d: done=%0b err=%0b, none required", cyc, done, err);
          end else begin
            h = sb.pop_front();
            chk("outcome_is_err", err_rise, h.is_err);
            chk("outcome_cycle", cyc, h.o);
            if (err_rise) err_mode = 1;
          end
        end
        if (sb.size() > 0 && cyc > sb[0].o) begin
          n_chk++;
          $display("FAIL missing_outcome at cycle %0d: nothing seen, required by cycle %0d", cyc, sb[0].o);
          void'(sb.pop_front());
        end
        if (err_mode && !err) err_mode = 0;
        have = (sb.size() > 0);
        if (have) h = sb[0];
        e_drv  = have && !h.noop && cyc >= h.a + 1 && cyc <= h.a + PW;
        e_busy = err_mode || (have && !h.noop && cyc >= h.a + 1 && cyc < h.o);
        chk("drive_en_S_R", {latch_en, latch_S, latch_R},
            {e_drv, e_drv && h.tgt, e_drv && !h.tgt});
        chk("busy", busy, e_busy);
        chk("cmd_ready", cmd_ready, !e_busy);
        chk("done_err_exclusive", done && err, 0);
        if (err_mode) chk("err_sticky", err, 1);
      end
      prev_err = err;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; cmd_valid = 1'b0; cmd_set = 1'b0; err_clr = 1'b0;
    q_fb = 1'b0; q_n_fb = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_en_S_R", {latch_en, latch_S, latch_R}, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    rst = 1'b0;

    // Reset in the middle of a drive pulse.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_set = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_drive_en", latch_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_en_S_R", {latch_en, latch_S, latch_R}, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy_done_err", {busy, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;

    run_txn(1'b1, 1, 2, 0);            // set, latch flips in cycle 2
    run_txn(1'b0, 1, 2, 1);            // reset command
    run_txn(1'b1, 0, 0, 0);            // no-op
    run_txn(1'b1, 1, 0, 2);            // stuck feedback -> timeout
    run_txn(1'b0, 2, 6, PW);           // invalid feedback, back-pressure held
    run_txn(1'b1, 1, PW + TO, 1);      // match on the last confirm cycle
    run_txn(1'b0, 1, PW + TO + 1, 0);  // one cycle too late -> timeout
    run_txn(1'b0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int md, cc;
      md = $urandom_range(0, 2);
      cc = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, PW + TO + 2));
      run_txn(1'($urandom_range(0, 1)), md, cc, $urandom_range(0, PW));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
